// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS subset core.
package mips_pkg;

   // Both memories hold 64 words, addressed by word index bits [7:2].
   localparam int IMEM_DEPTH = 64;
   localparam int DMEM_DEPTH = 64;
   localparam int MEM_AW     = 6;

   // Primary opcodes.
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   // R-type function codes.
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU operation select.
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_ctrl_e;

   // Decoded control for the instruction currently at the PC.
   // An all-zero value is a nop: no register write, no memory write, PC+4.
   typedef struct packed {
      logic      reg_write;
      logic      reg_dst;      // 1: write rd, 0: write rt
      logic      alu_src_imm;  // 1: ALU B operand is the sign-extended immediate
      logic      mem_write;
      logic      mem_to_reg;   // 1: write-back data comes from data memory
      logic      branch;
      logic      jump;
      alu_ctrl_e alu_ctrl;
   } ctrl_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/mips_if.sv
// Register-file access bundle: two combinational read ports, one write port.
interface mips_rf_if;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;

   // The core drives addresses and write data; the register file returns read data.
   modport master (output ra1, ra2, we, wa, wd, input  rd1, rd2);
   modport slave  (input  ra1, ra2, we, wa, wd, output rd1, rd2);
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file; $0 reads as zero and ignores writes.
module mips_regfile (
   input  logic      clk,
   input  logic      rst,
   mips_rf_if.slave  rf
);

   logic [31:0] regs_q [32];

   // Asynchronous clear of every register; single write port on the rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (rf.we && (rf.wa != 5'd0)) begin
         regs_q[rf.wa] <= rf.wd;
      end
   end

   // Combinational reads with $0 hard-wired to zero.
   assign rf.rd1 = (rf.ra1 == 5'd0) ? 32'h0 : regs_q[rf.ra1];
   assign rf.rd2 = (rf.ra2 == 5'd0) ? 32'h0 : regs_q[rf.ra2];

endmodule

// File: rtl/top.sv
// Single-cycle MIPS subset: fetch, decode, execute, memory and write-back in one clock.
module top
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] writedata,
   output logic [31:0] dataadr,
   output logic        memwrite
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] imm_ext;
   logic [31:0] src_b;
   logic [31:0] alu_y;
   logic [31:0] dmem_rdata;
   logic        branch_taken;
   ctrl_t       ctrl;

   logic [31:0] dmem_q [DMEM_DEPTH];

   mips_rf_if rf_bus ();

   // Fixed program image; words beyond the program read as zero (a nop).
   function automatic logic [31:0] rom_word(input logic [MEM_AW-1:0] idx);
      logic [31:0] w;
      case (idx)
         6'd0:    w = 32'h20020005;
         6'd1:    w = 32'h2003000c;
         6'd2:    w = 32'h2067fff7;
         6'd3:    w = 32'h00e22025;
         6'd4:    w = 32'h00642824;
         6'd5:    w = 32'h00a42820;
         6'd6:    w = 32'h10a7000a;
         6'd7:    w = 32'h0064202a;
         6'd8:    w = 32'h10800001;
         6'd9:    w = 32'h20050000;
         6'd10:   w = 32'h00e2202a;
         6'd11:   w = 32'h00853820;
         6'd12:   w = 32'h00e23822;
         6'd13:   w = 32'hac670044;
         6'd14:   w = 32'h8c020050;
         6'd15:   w = 32'h08000011;
         6'd16:   w = 32'h20020001;
         6'd17:   w = 32'hac020054;
         default: w = 32'h00000000;
      endcase
      return w;
   endfunction

   // Fetch and field split.
   assign instr   = rom_word(pc_q[7:2]);
   assign opcode  = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign rd      = instr[15:11];
   assign funct   = instr[5:0];
   assign imm_ext = sign_ext16(instr[15:0]);

   // Decode opcode/funct into control; anything unrecognised stays a nop.
   always_comb begin
      ctrl          = '0;
      ctrl.alu_ctrl = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            case (funct)
               FN_ADD: ctrl.alu_ctrl = ALU_ADD;
               FN_SUB: ctrl.alu_ctrl = ALU_SUB;
               FN_AND: ctrl.alu_ctrl = ALU_AND;
               FN_OR:  ctrl.alu_ctrl = ALU_OR;
               FN_SLT: ctrl.alu_ctrl = ALU_SLT;
               default: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.reg_dst   = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_to_reg  = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_write   = 1'b1;
         end
         OP_BEQ: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // Register file hookup: rd for R-type, rt for lw/addi; lw writes back memory data.
   assign rf_bus.ra1 = rs;
   assign rf_bus.ra2 = rt;
   assign rf_bus.we  = ctrl.reg_write;
   assign rf_bus.wa  = ctrl.reg_dst ? rd : rt;
   assign rf_bus.wd  = ctrl.mem_to_reg ? dmem_rdata : alu_y;

   mips_regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .rf  (rf_bus.slave)
   );

   assign src_b = ctrl.alu_src_imm ? imm_ext : rf_bus.rd2;

   // 32-bit ALU; arithmetic wraps, slt compares as signed.
   always_comb begin
      alu_y = 32'h0;
      case (ctrl.alu_ctrl)
         ALU_ADD: alu_y = rf_bus.rd1 + src_b;
         ALU_SUB: alu_y = rf_bus.rd1 - src_b;
         ALU_AND: alu_y = rf_bus.rd1 & src_b;
         ALU_OR:  alu_y = rf_bus.rd1 | src_b;
         ALU_SLT: alu_y = {31'b0, ($signed(rf_bus.rd1) < $signed(src_b))};
         default: alu_y = rf_bus.rd1 + src_b;
      endcase
   end

   // Data memory: combinational read, write on the rising edge; never cleared.
   assign dmem_rdata = dmem_q[alu_y[7:2]];

   // Store path for sw.
   always_ff @(posedge clk) begin
      if (ctrl.mem_write) begin
         dmem_q[alu_y[7:2]] <= rf_bus.rd2;
      end
   end

   assign dataadr   = alu_y;
   assign writedata = rf_bus.rd2;
   assign memwrite  = ctrl.mem_write;

   // Next-PC selection: jump, taken branch, or fall through.
   assign pc_plus4     = pc_q + 32'd4;
   assign branch_tgt   = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign jump_tgt     = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign branch_taken = ctrl.branch && (rf_bus.rd1 == rf_bus.rd2);

   always_comb begin
      pc_d = pc_plus4;
      if (ctrl.jump) begin
         pc_d = jump_tgt;
      end else if (branch_taken) begin
         pc_d = branch_tgt;
      end
   end

   // Program counter with asynchronous clear to address 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= 32'h0;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule

// File: tb/tb_top.sv
// Directed bench for the single-cycle MIPS core running its built-in program.
module tb_top;

   logic        clk;
   logic        rst;
   logic [31:0] writedata;
   logic [31:0] dataadr;
   logic        memwrite;

   int n_checks;
   int n_fail;

   // PC, ALU result and memwrite expected in cycles 1..16 after reset release.
   localparam logic [31:0] EXP_PC [16] = '{
      32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c,
      32'h20, 32'h28, 32'h2c, 32'h30, 32'h34, 32'h38, 32'h3c, 32'h44};
   localparam logic [31:0] EXP_ADR [16] = '{
      32'd5, 32'd12, 32'd3, 32'd7, 32'd4, 32'd11, 32'd0, 32'd0,
      32'd0, 32'd1, 32'd12, 32'd7, 32'd80, 32'd80, 32'd0, 32'd84};
   // Cycles whose ALU result is not defined by the instruction (beq, j) are skipped.
   localparam logic [15:0] ADR_CHK = 16'b1011_1111_1011_1111;
   localparam logic [15:0] EXP_MW  = 16'b1001_0000_0000_0000;

   top dut (
      .clk       (clk),
      .rst       (rst),
      .writedata (writedata),
      .dataadr   (dataadr),
      .memwrite  (memwrite)
   );

   // Clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Checks cycles 1..n starting at the current (negedge) sample point.
   task automatic run_trace(input int n, input string phase);
      for (int k = 0; k < n; k++) begin
         check($sformatf("%s pc c%0d", phase, k + 1), dut.pc_q, EXP_PC[k]);
         check($sformatf("%s memwrite c%0d", phase, k + 1), {31'b0, memwrite}, {31'b0, EXP_MW[k]});
         if (ADR_CHK[k]) begin
            check($sformatf("%s dataadr c%0d", phase, k + 1), dataadr, EXP_ADR[k]);
         end
         if (EXP_MW[k]) begin
            check($sformatf("%s writedata c%0d", phase, k + 1), writedata, 32'd7);
         end
         @(negedge clk);
      end
   endtask

   task automatic check_final(input string phase);
      check({phase, " $0"}, dut.u_regfile.regs_q[0], 32'd0);
      check({phase, " $2"}, dut.u_regfile.regs_q[2], 32'd7);
      check({phase, " $3"}, dut.u_regfile.regs_q[3], 32'd12);
      check({phase, " $7"}, dut.u_regfile.regs_q[7], 32'd7);
      check({phase, " mem20"}, dut.dmem_q[20], 32'd7);
      check({phase, " mem21"}, dut.dmem_q[21], 32'd7);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;

      // Held reset: PC at 0, first addi visible on the outputs.
      repeat (10) @(negedge clk);
      check("rst pc", dut.pc_q, 32'h0);
      check("rst memwrite", {31'b0, memwrite}, 32'd0);
      check("rst dataadr", dataadr, 32'd5);
      check("rst $2", dut.u_regfile.regs_q[2], 32'd0);

      // Full program run.
      rst = 1'b1;
      run_trace(16, "run1");
      check_final("run1");

      // Restart, then assert reset asynchronously mid-cycle at cycle 8.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_trace(7, "pre");
      #2;
      rst = 1'b0;
      #1;
      check("async pc", dut.pc_q, 32'h0);
      check("async dataadr", dataadr, 32'd5);
      check("async memwrite", {31'b0, memwrite}, 32'd0);
      check("async $5", dut.u_regfile.regs_q[5], 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_trace(16, "run2");
      check_final("run2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have no parameters; memory depths are fixed at 64 words each.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-004 writedata  output  32  data sent to data memory (register rt value of current instruction).
REQ-005 dataadr  output  32  data-memory byte address (ALU result of current instruction).
REQ-006 memwrite  output  1  high while the current instruction is sw.

Function
REQ-007 SHALL be a single-cycle 32-bit MIPS subset: one instruction fetched, executed and retired per clk cycle.
REQ-008 SHALL support add, sub, and, or, slt (R-type, opcode 0), lw (0x23), sw (0x2B), beq (0x04), addi (0x08), j (0x02).
REQ-009 Unsupported opcode/funct: SHALL behave as nop (no register or memory write, memwrite=0, PC+4).
REQ-010 Instruction memory: 64x32 ROM, combinational read at pc[7:2]; SHALL be preloaded with the program in REQ-020, all other words 0.
REQ-011 Data memory: 64x32 RAM; combinational read at dataadr[7:2]; write of writedata on rising clk when memwrite=1.
REQ-012 Register file: 32x32, two combinational read ports, one write port on rising clk; $0 SHALL always read 0 and ignore writes.
REQ-013 Write destination: rd for R-type, rt for lw/addi; write data is memory read data for lw, ALU result otherwise.
REQ-014 ALU: 32-bit two's complement; add/sub wrap modulo 2^32; slt is signed, result 1 or 0; no overflow trap.
REQ-015 addi/lw/sw immediate SHALL be sign-extended 16->32.
REQ-016 Next PC: beq taken (rs==rt) -> PC+4+(signext(imm)<<2); j -> {PC+4[31:28], target, 2'b00}; else PC+4.
REQ-017 Outputs SHALL be purely combinational from current PC, instruction and register contents.

Reset
REQ-018 rst=0 SHALL immediately clear PC to 0x00000000 and all registers to 0, independent of clk; data memory is not cleared.
REQ-019 During reset, outputs SHALL reflect instruction at address 0 (addi): memwrite=0; reset asserted mid-program restarts from address 0 on release.

Program
REQ-020 ROM words 0-17 (hex): 20020005 2003000c 2067fff7 00e22025 00642824 00a42820 10a7000a 0064202a 10800001 20050000 00e2202a 00853820 00e23822 ac670044 8c020050 08000011 20020001 ac020054.

Structure
REQ-021 Shared package SHALL hold opcode and funct constants, ALU-control encoding and memory-depth constants.
REQ-022 Control decoder, PC logic, datapath and both memories SHALL be inside top; the register file SHALL be one sub-module named mips_regfile.

Verification
REQ-023 Hold rst=0 10 cycles -> PC=0, memwrite=0, dataadr=5 (addi $2,$0,5 result).
REQ-024 Release rst, run -> 13th cycle after release: memwrite=1, dataadr=80, writedata=7.
REQ-025 Continue -> 16th cycle after release: memwrite=1, dataadr=84, writedata=7; no memwrite to any other address before it.
REQ-026 Branch check: beq at 0x18 not taken (11!=3), beq at 0x20 taken to 0x28; instruction at 0x24 never executes, at 0x40 skipped by j.
REQ-027 Assert rst=0 at cycle 8 asynchronously between edges -> PC=0 immediately; after release, same memwrite sequence as REQ-024/025.
REQ-028 Hierarchical check after run: $2=7, $3=12, $7=7, data word 20=7, word 21=7; $0 remains 0.
